// File: rtl/mux_41_pkg.sv
// Shared select-code definitions for the 4:1 operand multiplexer.
package mux_41_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_IN1 = 2'b00;
    localparam sel_t SEL_IN2 = 2'b01;
    localparam sel_t SEL_IN3 = 2'b10;
    localparam sel_t SEL_IN4 = 2'b11;

endpackage : mux_41_pkg

// File: rtl/mux_41_stage.sv
// Output register stage: holds the muxed data, the select code and a select-change flag.
module mux_41_stage
    import mux_41_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_i,
    input  sel_t             sel_i,
    output logic [WIDTH-1:0] data_o,
    output sel_t             sel_o,
    output logic             changed_o
);

    logic [WIDTH-1:0] data_q, data_d;
    sel_t             sel_q,  sel_d;
    logic             chg_q,  chg_d;

    // Next-state values: capture current mux result and flag a select change vs. the held code.
    always_comb begin
        data_d = data_i;
        sel_d  = sel_i;
        chg_d  = (sel_i != sel_q);
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            sel_q  <= SEL_IN1;
            chg_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            sel_q  <= sel_d;
            chg_q  <= chg_d;
        end
    end

    assign data_o    = data_q;
    assign sel_o     = sel_q;
    assign changed_o = chg_q;

endmodule : mux_41_stage

// File: rtl/mux_41.sv
// 4:1 WIDTH-bit multiplexer with a combinational output and a registered, change-flagged copy.
module mux_41
    import mux_41_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [WIDTH-1:0] in4,
    input  logic [1:0]       select,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic [1:0]       sel_q,
    output logic             sel_changed
);

    // Combinational steering; unknown select codes fall back to in1.
    always_comb begin
        out = in1;
        case (select)
            SEL_IN1: out = in1;
            SEL_IN2: out = in2;
            SEL_IN3: out = in3;
            SEL_IN4: out = in4;
            default: out = in1;
        endcase
    end

    mux_41_stage #(
        .WIDTH (WIDTH)
    ) u_stage (
        .clk       (clk),
        .rst       (rst),
        .data_i    (out),
        .sel_i     (select),
        .data_o    (out_q),
        .sel_o     (sel_q),
        .changed_o (sel_changed)
    );

endmodule : mux_41

// File: tb/tb_mux_41.sv
// Scoreboard bench for mux_41: WIDTH=4 and WIDTH=8 instances share clock, reset and select.
module tb_mux_41;

    typedef struct {
        logic [3:0] oq4;
        logic [7:0] oq8;
        logic [1:0] sq;
        logic       chg;
    } exp_t;

    logic       clk = 1'b0;
    logic       clk_run = 1'b0;
    logic       rst;
    logic [1:0] select;
    logic [3:0] a1, a2, a3, a4, out4, out_q4;
    logic [7:0] b1, b2, b3, b4, out8, out_q8;
    logic [1:0] sel_q4, sel_q8;
    logic       chg4, chg8;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference data tables, indexed by select code.
    logic [3:0] d4 [4];
    logic [7:0] d8 [4];
    bit   [1:0] m_sel;
    exp_t       sb_q [$];

    mux_41 #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .in1(a1), .in2(a2), .in3(a3), .in4(a4),
        .select(select), .out(out4), .out_q(out_q4), .sel_q(sel_q4), .sel_changed(chg4)
    );

    mux_41 #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in1(b1), .in2(b2), .in3(b3), .in4(b4),
        .select(select), .out(out8), .out_q(out_q8), .sel_q(sel_q8), .sel_changed(chg8)
    );

    initial begin
        wait (clk_run);
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply_data();
        a1 = d4[0]; a2 = d4[1]; a3 = d4[2]; a4 = d4[3];
        b1 = d8[0]; b2 = d8[1]; b3 = d8[2]; b4 = d8[3];
    endtask

    // Drive one cycle of stimulus, check the combinational path, queue the registered expectation.
    task automatic step(input bit r, input logic [1:0] s);
        exp_t e;
        @(negedge clk);
        rst    = r;
        select = s;
        apply_data();
        if (r) begin
            e.oq4 = '0; e.oq8 = '0; e.sq = 2'b00; e.chg = 1'b0;
            m_sel = 2'b00;
        end else begin
            e.oq4 = d4[s]; e.oq8 = d8[s]; e.sq = s; e.chg = (s != m_sel);
            m_sel = s;
        end
        sb_q.push_back(e);
        #1;
        check("out4", 8'(out4), 8'(d4[s]));
        check("out8", out8, d8[s]);
    endtask

    task automatic set_default_data();
        d4[0] = 4'b0001; d4[1] = 4'b0011; d4[2] = 4'b0111; d4[3] = 4'b1111;
        d8[0] = 8'h11;   d8[1] = 8'h22;   d8[2] = 8'h44;   d8[3] = 8'h88;
    endtask

    // Monitor: after every rising edge, pop the oldest expectation and compare registered outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("out_q4", 8'(out_q4), 8'(e.oq4));
                check("out_q8", out_q8, e.oq8);
                check("sel_q4", 8'(sel_q4), 8'(e.sq));
                check("sel_q8", 8'(sel_q8), 8'(e.sq));
                check("sel_changed4", 8'(chg4), 8'(e.chg));
                check("sel_changed8", 8'(chg8), 8'(e.chg));
            end
        end
    end

    initial begin
        rst    = 1'b0;
        select = 2'b00;
        m_sel  = 2'b00;
        set_default_data();
        apply_data();

        // Static sweep with no clock running.
        for (int s = 0; s < 4; s++) begin
            select = 2'(s);
            #10;
            check("static_out4", 8'(out4), 8'(d4[s]));
            check("static_out8", out8, d8[s]);
        end

        clk_run = 1'b1;

        // Initial reset.
        step(1'b1, 2'b00);
        step(1'b1, 2'b00);

        // Registered latency: select walks 00 -> 11 then holds.
        step(1'b0, 2'b00);
        step(1'b0, 2'b01);
        step(1'b0, 2'b10);
        step(1'b0, 2'b11);
        step(1'b0, 2'b11);
        step(1'b0, 2'b11);

        // Unselected inputs toggle while select = 10.
        step(1'b0, 2'b10);
        for (int i = 0; i < 8; i++) begin
            d4[0] = 4'($urandom); d4[1] = 4'($urandom); d4[3] = 4'($urandom);
            d8[0] = 8'($urandom); d8[1] = 8'($urandom); d8[3] = 8'($urandom);
            step(1'b0, 2'b10);
        end
        d4[2] = 4'b1010;
        d8[2] = 8'hA5;
        step(1'b0, 2'b10);
        step(1'b0, 2'b10);

        // Reset mid-stream with select = 11.
        set_default_data();
        step(1'b0, 2'b11);
        step(1'b0, 2'b11);
        step(1'b1, 2'b11);
        step(1'b1, 2'b11);
        step(1'b0, 2'b11);
        step(1'b0, 2'b11);

        // Simultaneous select and data change.
        step(1'b0, 2'b00);
        d4[1] = 4'b0101;
        d8[1] = 8'h55;
        step(1'b0, 2'b01);
        step(1'b0, 2'b01);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 60; i++) begin
            for (int k = 0; k < 4; k++) begin
                d4[k] = 4'($urandom);
                d8[k] = 8'($urandom);
            end
            step(($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)));
        end

        // Let the last expectation drain, then confirm nothing is left unchecked.
        @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", 8'(sb_q.size()), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_mux_41
